// File: rtl/alarma_pkg.sv
// Shared types and time arithmetic for the multi-channel alarm.
// Latency: combinational helpers only.
// Backpressure: none; pure definitions.
package alarma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RINGING,
        SNOOZED
    } alarm_state_e;

    localparam logic [6:0] MIN_PER_HOUR = 7'd60;
    localparam logic [4:0] HOUR_PER_DAY = 5'd24;

    typedef struct packed {
        logic [4:0] ore;
        logic [5:0] minute;
    } alarm_time_t;

    // Add m minutes (0..59) to a valid time of day; minutes carry into
    // the hour and the hour wraps at midnight.
    function automatic alarm_time_t time_add(input alarm_time_t t, input logic [5:0] m);
        alarm_time_t r;
        logic [6:0]  msum;
        r    = t;
        msum = {1'b0, t.minute} + {1'b0, m};
        if (msum >= MIN_PER_HOUR) begin
            msum  = msum - MIN_PER_HOUR;
            r.ore = (t.ore == HOUR_PER_DAY - 5'd1) ? 5'd0 : t.ore + 5'd1;
        end
        r.minute = msum[5:0];
        return r;
    endfunction

    function automatic logic time_valid(input alarm_time_t t);
        return ({1'b0, t.minute} < MIN_PER_HOUR) && (t.ore < HOUR_PER_DAY);
    endfunction

endpackage

// File: rtl/alarma_if.sv
// Control/status bundle between the time source, user controls and the alarm.
// Latency: wires only.
// Backpressure: none; all signals are levels or 1-cycle pulses.
interface alarma_if #(
    parameter int N_ALARM = 4,
    parameter int ID_W    = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
);
    logic [5:0]         minute_counter;
    logic [4:0]         ore_counter;
    logic               tick_min;
    logic               load;
    logic [ID_W-1:0]    load_id;
    logic               load_en;
    logic [5:0]         minute_setare;
    logic [4:0]         ore_setare;
    logic               snooze;
    logic               stop;
    logic [N_ALARM-1:0] ring;
    logic               ring_any;
    logic [N_ALARM-1:0] armed;
    logic               load_err;

    modport master (
        output minute_counter, ore_counter, tick_min, load, load_id, load_en,
               minute_setare, ore_setare, snooze, stop,
        input  ring, ring_any, armed, load_err
    );

    modport slave (
        input  minute_counter, ore_counter, tick_min, load, load_id, load_en,
               minute_setare, ore_setare, snooze, stop,
        output ring, ring_any, armed, load_err
    );
endinterface

// File: rtl/alarma_chan.sv
// One alarm channel: IDLE/ARMED/RINGING/SNOOZED FSM, set/target times, snooze count.
// Latency: ring/armed are registered, valid 1 clock after the causing edge.
// Backpressure: none. Optional auto-dismiss built only with ALARMA_RING_TIMEOUT_EN.
module alarma_chan import alarma_pkg::*; #(
    parameter int SNOOZE_MIN   = 10,
    parameter int MAX_SNOOZE   = 3
`ifdef ALARMA_RING_TIMEOUT_EN
    ,
    parameter int RING_TMO_MIN = 5
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_min,
    input  alarm_time_t now_t,
    input  logic        load_hit,
    input  logic        load_en,
    input  alarm_time_t load_t,
    input  logic        snooze,
    input  logic        stop,
    output logic        ring,
    output logic        armed
);
    localparam int         SC_W       = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [5:0] SNOOZE_INC = 6'(SNOOZE_MIN);

    alarm_state_e    state_q, state_d;
    alarm_time_t     set_q, set_d;
    alarm_time_t     target_q, target_d;
    logic [SC_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic            ring_q, ring_d;
    logic            armed_q, armed_d;
    logic            match;

`ifdef ALARMA_RING_TIMEOUT_EN
    localparam int    TMO_W = $clog2(RING_TMO_MIN + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit;
`endif

    // Next state: load overrides everything, then stop, snooze, (timeout), match.
    always_comb begin
        state_d      = state_q;
        set_d        = set_q;
        target_d     = target_q;
        snooze_cnt_d = snooze_cnt_q;
        match        = tick_min && (now_t == target_q);
`ifdef ALARMA_RING_TIMEOUT_EN
        tmo_hit      = tick_min && ((int'(tmo_cnt_q) + 1) >= RING_TMO_MIN);
`endif
        if (load_hit) begin
            if (load_en) begin
                state_d  = ARMED;
                set_d    = load_t;
                target_d = load_t;
            end else begin
                state_d  = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (match) begin
                        state_d      = RINGING;
                        snooze_cnt_d = '0;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_d  = ARMED;
                        target_d = set_q;
                    end else if (snooze && (int'(snooze_cnt_q) < MAX_SNOOZE)) begin
                        state_d      = SNOOZED;
                        target_d     = time_add(target_q, SNOOZE_INC);
                        snooze_cnt_d = snooze_cnt_q + SC_W'(1);
                    end
`ifdef ALARMA_RING_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_d  = ARMED;
                        target_d = set_q;
                    end
`endif
                end
                SNOOZED: begin
                    if (stop) begin
                        state_d  = ARMED;
                        target_d = set_q;
                    end else if (match) begin
                        state_d  = RINGING;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef ALARMA_RING_TIMEOUT_EN
        // Count minutes spent ringing; cleared whenever the channel is not ringing.
        if (state_d != RINGING) begin
            tmo_cnt_d = '0;
        end else if (state_q == RINGING && tick_min) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
`endif
        ring_d  = (state_d == RINGING);
        armed_d = (state_d != IDLE);
    end

    // State and output registers; reset drops ring/armed asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            set_q        <= '0;
            target_q     <= '0;
            snooze_cnt_q <= '0;
            ring_q       <= 1'b0;
            armed_q      <= 1'b0;
`ifdef ALARMA_RING_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            target_q     <= target_d;
            snooze_cnt_q <= snooze_cnt_d;
            ring_q       <= ring_d;
            armed_q      <= armed_d;
`ifdef ALARMA_RING_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign ring  = ring_q;
    assign armed = armed_q;

endmodule

// File: rtl/alarma_multi.sv
// N-channel daily alarm with shared snooze/stop; load decode and error pulse live here.
// Latency: ring/armed/load_err registered, 1 clock after the causing edge.
// Backpressure: none. ALARMA_RING_TIMEOUT_EN adds per-channel ring auto-dismiss.
module alarma_multi import alarma_pkg::*; #(
    parameter int N_ALARM      = 4,
    parameter int SNOOZE_MIN   = 10,
    parameter int MAX_SNOOZE   = 3,
`ifdef ALARMA_RING_TIMEOUT_EN
    parameter int RING_TMO_MIN = 5,
`endif
    parameter int ID_W         = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic     clock,
    input  logic     reset,
    alarma_if.slave  bus
);
    alarm_time_t        now_t;
    alarm_time_t        load_t;
    logic               id_ok;
    logic               time_ok;
    logic [N_ALARM-1:0] load_hit;
    logic [N_ALARM-1:0] ring_w;
    logic [N_ALARM-1:0] armed_w;
    logic               load_err_d, load_err_q;

    assign now_t  = '{ore: bus.ore_counter, minute: bus.minute_counter};
    assign load_t = '{ore: bus.ore_setare, minute: bus.minute_setare};

    // Decode a load: only an in-range id with a valid time reaches a channel.
    always_comb begin
        id_ok      = int'(bus.load_id) < N_ALARM;
        time_ok    = time_valid(load_t);
        load_err_d = bus.load && !(id_ok && time_ok);
        for (int i = 0; i < N_ALARM; i++) begin
            load_hit[i] = bus.load && id_ok && time_ok && (int'(bus.load_id) == i);
        end
    end

    // Rejected-load pulse register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    for (genvar g = 0; g < N_ALARM; g++) begin : g_chan
        alarma_chan #(
            .SNOOZE_MIN   (SNOOZE_MIN),
            .MAX_SNOOZE   (MAX_SNOOZE)
`ifdef ALARMA_RING_TIMEOUT_EN
            ,
            .RING_TMO_MIN (RING_TMO_MIN)
`endif
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .tick_min (bus.tick_min),
            .now_t    (now_t),
            .load_hit (load_hit[g]),
            .load_en  (bus.load_en),
            .load_t   (load_t),
            .snooze   (bus.snooze),
            .stop     (bus.stop),
            .ring     (ring_w[g]),
            .armed    (armed_w[g])
        );
    end

    assign bus.ring     = ring_w;
    assign bus.ring_any = |ring_w;
    assign bus.armed    = armed_w;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_alarma_multi.sv
// Randomized + directed bench for alarma_multi with a minute-of-day reference model.
// Driver pushes expected outputs per cycle; monitor pops and compares after each edge.
// Timeout scenario exercised only when ALARMA_RING_TIMEOUT_EN is defined.
module tb_alarma_multi;
    localparam int N    = 4;
    localparam int IDW  = 3;
    localparam int SNZ  = 10;
    localparam int MAXS = 3;
    localparam int TMO  = 5;
    localparam int DAY  = 1440;

    localparam int M_OFF  = 0;
    localparam int M_WAIT = 1;
    localparam int M_RING = 2;
    localparam int M_SNZ  = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alarma_if #(.N_ALARM(N), .ID_W(IDW)) bus();

    alarma_multi #(
        .N_ALARM    (N),
        .SNOOZE_MIN (SNZ),
        .MAX_SNOOZE (MAXS),
        .ID_W       (IDW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] ring;
        logic [N-1:0] armed;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   now_m = 0;

    int m_mode [N];
    int m_set  [N];
    int m_tgt  [N];
    int m_sc   [N];
    int m_tc   [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = M_OFF; m_set[i] = 0; m_tgt[i] = 0; m_sc[i] = 0; m_tc[i] = 0;
        end
    endtask

    // Reference behaviour with times as minutes since midnight.
    task automatic model_step(input bit tk, input bit ld, input int lid, input bit len,
                              input int lh, input int lm, input bit snz, input bit stp);
        exp_t e;
        bit   ok;
        ok    = (lid < N) && (lm < 60) && (lh < 24);
        e.err = ld && !ok;
        for (int i = 0; i < N; i++) begin
            if (ld && ok && lid == i) begin
                if (len) begin
                    m_mode[i] = M_WAIT; m_set[i] = lh * 60 + lm; m_tgt[i] = m_set[i];
                end else begin
                    m_mode[i] = M_OFF;
                end
            end else begin
                case (m_mode[i])
                    M_WAIT: if (tk && now_m == m_tgt[i]) begin
                        m_mode[i] = M_RING; m_sc[i] = 0; m_tc[i] = 0;
                    end
                    M_RING: begin
                        if (stp) begin
                            m_mode[i] = M_WAIT; m_tgt[i] = m_set[i];
                        end else if (snz && m_sc[i] < MAXS) begin
                            m_mode[i] = M_SNZ; m_tgt[i] = (m_tgt[i] + SNZ) % DAY; m_sc[i]++;
                        end
`ifdef ALARMA_RING_TIMEOUT_EN
                        else if (tk) begin
                            m_tc[i]++;
                            if (m_tc[i] == TMO) begin
                                m_mode[i] = M_WAIT; m_tgt[i] = m_set[i];
                            end
                        end
`endif
                    end
                    M_SNZ: begin
                        if (stp) begin
                            m_mode[i] = M_WAIT; m_tgt[i] = m_set[i];
                        end else if (tk && now_m == m_tgt[i]) begin
                            m_mode[i] = M_RING; m_tc[i] = 0;
                        end
                    end
                    default: ;
                endcase
            end
            e.ring[i]  = (m_mode[i] == M_RING);
            e.armed[i] = (m_mode[i] != M_OFF);
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit tk, input bit ld, input int lid, input bit len,
                         input int lh, input int lm, input bit snz, input bit stp);
        @(negedge clock);
        bus.tick_min       = tk;
        bus.minute_counter = 6'(now_m % 60);
        bus.ore_counter    = 5'(now_m / 60);
        bus.load           = ld;
        bus.load_id        = IDW'(lid);
        bus.load_en        = len;
        bus.ore_setare     = 5'(lh);
        bus.minute_setare  = 6'(lm);
        bus.snooze         = snz;
        bus.stop           = stp;
        model_step(tk, ld, lid, len, lh, lm, snz, stp);
    endtask

    task automatic idle();                    drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic tick_at(input int t);      now_m = t % DAY; drive(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_load(input int id, input bit en, input int h, input int m);
        drive(0, 1, id, en, h, m, 0, 0);
    endtask
    task automatic snooze_p();                drive(0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic stop_p();                  drive(0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic post();                    @(posedge clock); #2; endtask

    // Monitor: one expected record per driven cycle, compared after the edge.
    exp_t mon_e;
    always @(posedge clock) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("ring",     32'(bus.ring),     32'(mon_e.ring));
            check("armed",    32'(bus.armed),    32'(mon_e.armed));
            check("load_err", 32'(bus.load_err), 32'(mon_e.err));
            check("ring_any", 32'(bus.ring_any), 32'(|mon_e.ring));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        bus.tick_min = 0; bus.minute_counter = 0; bus.ore_counter = 0;
        bus.load = 0; bus.load_id = 0; bus.load_en = 0;
        bus.minute_setare = 0; bus.ore_setare = 0; bus.snooze = 0; bus.stop = 0;
        model_reset();

        // Reset state
        #12;
        check("rst_ring",     32'(bus.ring),     0);
        check("rst_ring_any", 32'(bus.ring_any), 0);
        check("rst_armed",    32'(bus.armed),    0);
        check("rst_load_err", 32'(bus.load_err), 0);
        @(negedge clock); reset = 1'b0;

        // Basic ring and stop, then re-ring next day
        do_load(0, 1, 7, 30);
        tick_at(7 * 60 + 29);
        tick_at(7 * 60 + 30); post(); check("t1_ring0", 32'(bus.ring[0]), 1);
        stop_p();             post(); check("t1_stop_ring0", 32'(bus.ring[0]), 0);
        check("t1_armed0", 32'(bus.armed[0]), 1);
        tick_at(7 * 60 + 30); post(); check("t1_rering0", 32'(bus.ring[0]), 1);
        stop_p();

        // Snooze across midnight
        do_load(1, 1, 23, 55);
        tick_at(23 * 60 + 55); post(); check("t2_ring1", 32'(bus.ring[1]), 1);
        snooze_p();            post(); check("t2_snz_ring1", 32'(bus.ring[1]), 0);
        tick_at(4);            post(); check("t2_early_ring1", 32'(bus.ring[1]), 0);
        tick_at(5);            post(); check("t2_wrap_ring1", 32'(bus.ring[1]), 1);
        stop_p();

        // Snooze limit
        do_load(2, 1, 10, 0);
        tick_at(600); post(); check("t3_ring2", 32'(bus.ring[2]), 1);
        for (int k = 1; k <= 3; k++) begin
            snooze_p();          post(); check("t3_snz_ring2", 32'(bus.ring[2]), 0);
            tick_at(600 + 10*k); post(); check("t3_rering2", 32'(bus.ring[2]), 1);
        end
        snooze_p(); post(); check("t3_snz4_ignored", 32'(bus.ring[2]), 1);
        stop_p();

        // Invalid loads
        do_load(0, 1, 8, 60); post(); check("t4_err_time", 32'(bus.load_err), 1);
        check("t4_armed0_kept", 32'(bus.armed[0]), 1);
        idle();               post(); check("t4_err_pulse", 32'(bus.load_err), 0);
        do_load(5, 1, 8, 0);  post(); check("t4_err_id", 32'(bus.load_err), 1);
        check("t4_armed_vec", 32'(bus.armed), 32'h7);
        tick_at(8 * 60);      post(); check("t4_no_ring0", 32'(bus.ring[0]), 0);
        tick_at(7 * 60 + 30); post(); check("t4_keep_ring0", 32'(bus.ring[0]), 1);
        stop_p();

        // Simultaneous rings, snooze+stop together
        do_load(0, 1, 6, 0);
        do_load(3, 1, 6, 0);
        tick_at(360); post(); check("t5_ring_both", 32'(bus.ring), 32'h9);
        check("t5_ring_any", 32'(bus.ring_any), 1);
        drive(0, 0, 0, 0, 0, 0, 1, 1); post(); check("t5_stop_wins", 32'(bus.ring), 0);
        check("t5_armed03", 32'(bus.armed & 4'h9), 32'h9);
        tick_at(370); post(); check("t5_no_snooze_ring", 32'(bus.ring), 0);

`ifdef ALARMA_RING_TIMEOUT_EN
        // Auto-dismiss after five minutes ringing
        do_load(1, 1, 12, 0);
        tick_at(720); post(); check("t6_ring1", 32'(bus.ring[1]), 1);
        for (int k = 1; k <= 4; k++) begin
            tick_at(720 + k); post(); check("t6_still_ring1", 32'(bus.ring[1]), 1);
        end
        tick_at(725); post(); check("t6_tmo_ring1", 32'(bus.ring[1]), 0);
        check("t6_tmo_armed1", 32'(bus.armed[1]), 1);
`endif

        // Reset mid-ring
        do_load(2, 1, 13, 0);
        tick_at(780); post(); check("t6_pre_rst_ring2", 32'(bus.ring[2]), 1);
        idle();
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("t6_rst_ring",     32'(bus.ring),     0);
        check("t6_rst_ring_any", 32'(bus.ring_any), 0);
        check("t6_rst_armed",    32'(bus.armed),    0);
        check("t6_rst_load_err", 32'(bus.load_err), 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            bit tk, ld, len, snz, stp;
            int lid, lh, lm, t;
            tk = ($urandom_range(0, 99) < 45);
            if (tk) begin
                if ($urandom_range(0, 3) == 0) now_m = m_tgt[$urandom_range(0, N - 1)];
                else                           now_m = (now_m + 1) % DAY;
            end
            ld  = ($urandom_range(0, 19) == 0);
            lid = $urandom_range(0, 7);
            len = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                t  = (now_m + $urandom_range(0, 3)) % DAY;
                lh = t / 60; lm = t % 60;
            end else begin
                lh = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
                lm = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
            end
            snz = ($urandom_range(0, 11) == 0);
            stp = ($urandom_range(0, 29) == 0);
            drive(tk, ld, lid, len, lh, lm, snz, stp);
        end

        idle();
        repeat (3) @(posedge clock);
        #2;
        check("queue_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
